// File: rtl/lion_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lion_mem_arbiter
// Purpose  : Shares the core's single valid/ready memory port between the
//            instruction-fetch requester (I) and the load/store requester
//            (D). D has priority, but a streak limiter bounds how many D
//            grants can pass a pending I request. A wait counter raises a
//            sticky timeout flag when a bus transaction stalls too long.
// Ports    : clock, reset      - single clock, synchronous active-high reset
//            i_valid/i_addr    - fetch request (held until i_ready)
//            i_ready/i_rdata   - fetch completion strobe / data
//            d_valid/d_addr/d_wdata/d_wstrb - data request (wstrb 0 = load)
//            d_ready/d_rdata   - data completion strobe / load data
//            mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb - registered bus request
//            mem_rdata/mem_ready - bus response
//            timeout           - sticky stalled-bus flag
// Revision : 1.0 - initial release
// ============================================================================
module lion_mem_arbiter #(
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout
);

  localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);
  localparam logic [WW-1:0] WAIT_LIM   = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           mem_valid_q, mem_valid_d;
  logic           mem_instr_q, mem_instr_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic [3:0]     mem_wstrb_q, mem_wstrb_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic           timeout_q, timeout_d;

  logic w_i_done, w_d_done, w_arb_en, w_i_req, w_d_req, w_i_forced;
  logic w_grant_i, w_grant_d;

  // Completion strobes. Gated by reset so that a transaction abandoned by
  // reset never produces a ready pulse, even if the bus answers that cycle.
  always_comb begin
    w_i_done = !reset && (state_q == ST_BUSY_I) && mem_valid_q && mem_ready;
    w_d_done = !reset && (state_q == ST_BUSY_D) && mem_valid_q && mem_ready;
  end

  // Arbitration happens when idle or on a completion cycle (back-to-back).
  // A completing requester still shows valid this cycle; masking it keeps
  // the same request from being issued a second time.
  always_comb begin
    w_arb_en   = (state_q == ST_IDLE) || w_i_done || w_d_done;
    w_i_req    = i_valid && !w_i_done;
    w_d_req    = d_valid && !w_d_done;
    w_i_forced = w_i_req && (streak_q == STREAK_LIM);
    w_grant_d  = w_arb_en && w_d_req && !w_i_forced;
    w_grant_i  = w_arb_en && w_i_req && !w_grant_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_instr_d = mem_instr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    streak_d    = streak_q;
    wait_cnt_d  = wait_cnt_q;

    if (w_grant_d) begin
      state_d     = ST_BUSY_D;
      mem_valid_d = 1'b1;
      mem_instr_d = 1'b0;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_wstrb_d = d_wstrb;
      wait_cnt_d  = '0;
      // Only D grants that pass over a waiting fetch count toward the streak.
      if (i_valid) begin
        streak_d = (streak_q == STREAK_LIM) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end else if (w_grant_i) begin
      state_d     = ST_BUSY_I;
      mem_valid_d = 1'b1;
      mem_instr_d = 1'b1;
      mem_addr_d  = i_addr;
      mem_wdata_d = '0;
      mem_wstrb_d = '0;
      wait_cnt_d  = '0;
      streak_d    = '0;
    end else if (w_arb_en) begin
      state_d     = ST_IDLE;
      mem_valid_d = 1'b0;
    end else if (mem_valid_q && !mem_ready && (wait_cnt_q != WAIT_LIM)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // Sticky flag; the stalled transaction itself keeps waiting.
    timeout_d = timeout_q || (wait_cnt_d == WAIT_LIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      streak_q    <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      streak_q    <= streak_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    i_ready   = w_i_done;
    d_ready   = w_d_done;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    mem_valid = mem_valid_q;
    mem_instr = mem_instr_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_wstrb = mem_wstrb_q;
    timeout   = timeout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_lion_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lion_mem_arbiter
// Purpose  : Directed self-checking bench for lion_mem_arbiter
//            (STREAK_MAX=4, TIMEOUT=16). Inputs change 1 time unit after
//            the rising edge; outputs are checked 1 unit later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lion_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_valid, d_valid, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wstrb;
  logic        i_ready, d_ready, mem_valid, mem_instr, timeout;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;

  lion_mem_arbiter #(.STREAK_MAX(4), .TIMEOUT(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_valid   (d_valid),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;

    // ---- 1: reset with both requesters active, then first grant is D
    i_valid = 1'b1; i_addr = 32'h80;
    d_valid = 1'b1; d_addr = 32'h40; d_wdata = 32'h11; d_wstrb = 4'h0;
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_i_ready", i_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_timeout", timeout, 0);
    end
    step(); reset = 1'b0; #1;
    chk("post_rst_idle", mem_valid, 0);
    step(); #1;
    chk("first_grant_valid", mem_valid, 1);
    chk("first_grant_instr", mem_instr, 0);
    chk("first_grant_addr", mem_addr, 32'h40);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001; #1;
    chk("first_d_ready", d_ready, 1);
    chk("first_i_ready_quiet", i_ready, 0);
    chk("first_d_rdata", d_rdata, 32'hCAFE0001);
    step(); d_valid = 1'b0; #1;
    chk("bb_i_instr", mem_instr, 1);
    chk("bb_i_addr", mem_addr, 32'h80);
    chk("bb_i_wdata", mem_wdata, 0);
    chk("bb_i_wstrb", mem_wstrb, 0);
    chk("bb_i_ready", i_ready, 1);
    chk("bb_d_ready_quiet", d_ready, 0);
    i_valid = 1'b0;
    step(); #1;
    chk("t1_idle", mem_valid, 0);

    // ---- 2: fetch-only stream, mem_ready always 1
    i_valid = 1'b1; i_addr = 32'h100; mem_rdata = 32'h12345678;
    step(); #1;
    chk("f1_valid", mem_valid, 1);
    chk("f1_instr", mem_instr, 1);
    chk("f1_addr", mem_addr, 32'h100);
    chk("f1_i_ready", i_ready, 1);
    chk("f1_i_rdata", i_rdata, 32'h12345678);
    i_addr = 32'h104;
    step(); #1;
    chk("f_gap_valid", mem_valid, 0);
    chk("f_gap_ready", i_ready, 0);
    step(); #1;
    chk("f2_valid", mem_valid, 1);
    chk("f2_addr", mem_addr, 32'h104);
    chk("f2_i_ready", i_ready, 1);
    i_valid = 1'b0;
    step(); #1;
    chk("t2_idle", mem_valid, 0);

    // ---- 3: store with three wait cycles
    mem_ready = 1'b0;
    d_valid = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) mem_ready = 1'b1;
      #1;
      chk("st_valid", mem_valid, 1);
      chk("st_instr", mem_instr, 0);
      chk("st_addr", mem_addr, 32'h2000);
      chk("st_wdata", mem_wdata, 32'hDEADBEEF);
      chk("st_wstrb", mem_wstrb, 4'hF);
      chk("st_d_ready", d_ready, (k == 4));
    end
    step(); d_valid = 1'b0; mem_ready = 1'b0; #1;
    chk("t3_idle", mem_valid, 0);

    // ---- 4a: both held high -> strict D,I alternation via masking
    mem_ready = 1'b1;
    d_valid = 1'b1; d_addr = 32'h3000; d_wstrb = 4'h0;
    i_valid = 1'b1; i_addr = 32'h200;
    for (int k = 0; k < 8; k++) begin
      step(); #1;
      chk("alt_instr", mem_instr, k % 2);
      chk("alt_d_ready", d_ready, (k % 2) == 0);
      chk("alt_i_ready", i_ready, (k % 2) == 1);
      if (k == 6) d_valid = 1'b0;
      if (k == 7) i_valid = 1'b0;
    end
    step(); #1;
    chk("t4a_idle", mem_valid, 0);

    // ---- 4b: fetch presented only in idle arbitration cycles (withdrawn on
    // D completion cycles) so D can win repeatedly; the limiter must hand
    // the fifth contested grant to I.
    d_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      i_valid = 1'b1; #1;
      chk("streak_idle", mem_valid, 0);
      step(); i_valid = 1'b0; #1;
      chk("streak_d_valid", mem_valid, 1);
      chk("streak_d_instr", mem_instr, 0);
      chk("streak_d_ready", d_ready, 1);
      step();
    end
    i_valid = 1'b1; #1;
    chk("streak_pre_force", mem_valid, 0);
    step(); #1;
    chk("forced_i_instr", mem_instr, 1);
    chk("forced_i_ready", i_ready, 1);
    chk("forced_d_quiet", d_ready, 0);
    i_valid = 1'b0;
    step(); d_valid = 1'b0; #1;
    chk("after_force_d_instr", mem_instr, 0);
    chk("after_force_d_ready", d_ready, 1);
    step(); #1;
    chk("t4b_idle", mem_valid, 0);

    // ---- 5: 20 stall cycles, timeout sets after the 16th
    mem_ready = 1'b0;
    d_valid = 1'b1; d_addr = 32'h4000; d_wstrb = 4'h0;
    for (int w = 1; w <= 20; w++) begin
      step(); #1;
      chk("to_flag", timeout, (w > 16));
      chk("to_d_wait", d_ready, 0);
      chk("to_valid_held", mem_valid, 1);
    end
    step(); mem_ready = 1'b1; mem_rdata = 32'h0000ABCD; #1;
    chk("to_complete_ready", d_ready, 1);
    chk("to_complete_rdata", d_rdata, 32'h0000ABCD);
    chk("to_complete_flag", timeout, 1);
    step(); d_valid = 1'b0; mem_ready = 1'b0; #1;
    chk("to_sticky", timeout, 1);
    chk("t5_idle", mem_valid, 0);

    // ---- 6: reset while BUSY_D with bus stalled
    d_valid = 1'b1; d_addr = 32'h5000; d_wdata = 32'h55; d_wstrb = 4'h3;
    step(); #1;
    chk("r6_busy", mem_valid, 1);
    reset = 1'b1; #1;
    chk("r6_no_ready_in_reset", d_ready, 0);
    step(); reset = 1'b0; #1;
    chk("r6_valid_dropped", mem_valid, 0);
    chk("r6_d_ready", d_ready, 0);
    chk("r6_timeout_cleared", timeout, 0);
    step(); #1;
    chk("r6_regrant_valid", mem_valid, 1);
    chk("r6_regrant_addr", mem_addr, 32'h5000);
    chk("r6_regrant_wstrb", mem_wstrb, 4'h3);
    mem_ready = 1'b1; #1;
    chk("r6_regrant_ready", d_ready, 1);
    step(); d_valid = 1'b0; mem_ready = 1'b0; #1;
    chk("r6_idle", mem_valid, 0);
    chk("r6_timeout_low", timeout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
